muldiv_unit: RTL and testbench

MULDIV_UNIT -- requirements
Module: muldiv_unit

---
 rtl/muldiv_pkg.sv | 29 ++
 rtl/muldiv_step.sv | 42 ++++
 rtl/muldiv_unit.sv | 173 +++++++++++++++++
 tb/tb_muldiv_unit.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit: op codes, FSM
// states and the default operand width.
package muldiv_pkg;

    localparam int unsigned WidthDefault = 32;

    // 110 and 111 are reserved and are never enumerated.
    typedef enum logic [2:0] {
        OpMultu = 3'b000,
        OpMult  = 3'b001,
        OpDivu  = 3'b010,
        OpDiv   = 3'b011,
        OpMthi  = 3'b100,
        OpMtlo  = 3'b101
    } op_e;

    typedef enum logic [1:0] {
        StIdle = 2'b00,
        StRun  = 2'b01,
        StFix  = 2'b10,
        StDone = 2'b11
    } state_e;

    // Multiply and divide ops all have op[2] clear.
    function automatic logic is_muldiv(input logic [2:0] op);
        return ~op[2];
    endfunction

endpackage

// File: rtl/muldiv_step.sv
// One combinational iteration of the multiply/divide datapath.
// div_mode = 0: shift-add multiply step on {upper, lower} (lower holds multiplier).
// div_mode = 1: restoring shift-subtract divide step (upper = partial remainder,
// lower = dividend bits shifting out / quotient bits shifting in).
module muldiv_step
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = WidthDefault
) (
    input  logic             div_mode,
    input  logic [WIDTH-1:0] upper,
    input  logic [WIDTH-1:0] lower,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] upper_next,
    output logic [WIDTH-1:0] lower_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             fits;

    // Compute both step flavours and select by mode.
    always_comb begin
        sum     = {1'b0, upper} + (lower[0] ? {1'b0, operand} : '0);
        shifted = {upper, lower[WIDTH-1]};
        fits    = shifted >= {1'b0, operand};
        // Only used when fits, where the true difference is below 2^WIDTH.
        diff    = shifted[WIDTH-1:0] - operand;
        if (!div_mode) begin
            upper_next = sum[WIDTH:1];
            lower_next = {sum[0], lower[WIDTH-1:1]};
        end else if (fits) begin
            upper_next = diff;
            lower_next = {lower[WIDTH-2:0], 1'b1};
        end else begin
            upper_next = shifted[WIDTH-1:0];
            lower_next = {lower[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative MIPS-style HI/LO multiply/divide unit.
// Operands are reduced to magnitudes on capture, iterated WIDTH times by
// muldiv_step, then sign-corrected in a single FIX cycle.
// Define MULDIV_SIGNED_EN to make MULT/DIV signed; otherwise op[0] is ignored.
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int unsigned WIDTH = WidthDefault
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             divzero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [6:0] LastCnt = 7'(WIDTH - 1);

    state_e             state_q, state_d;
    logic [6:0]         cnt_q, cnt_d;
    logic               div_q, div_d;
    logic               sgn_q, sgn_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]   upper_q, upper_d, lower_q, lower_d, opnd_q, opnd_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               divzero_q, divzero_d;

    logic               sgn_in;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic [WIDTH-1:0]   step_upper, step_lower;
    logic [2*WIDTH-1:0] prod, prod_fix;

`ifdef MULDIV_SIGNED_EN
    assign sgn_in = op[0];
`else
    assign sgn_in = 1'b0;
`endif

    // Magnitudes of the incoming operands for the unsigned iteration core.
    always_comb begin
        a_mag = (sgn_in && a[WIDTH-1]) ? -a : a;
        b_mag = (sgn_in && b[WIDTH-1]) ? -b : b;
    end

    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .div_mode   (div_q),
        .upper      (upper_q),
        .lower      (lower_q),
        .operand    (opnd_q),
        .upper_next (step_upper),
        .lower_next (step_lower)
    );

    // FSM next-state, datapath iteration and FIX-cycle sign correction.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        div_d     = div_q;
        sgn_d     = sgn_q;
        a_d       = a_q;
        b_d       = b_q;
        upper_d   = upper_q;
        lower_d   = lower_q;
        opnd_d    = opnd_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        divzero_d = 1'b0;
        prod      = {upper_q, lower_q};
        prod_fix  = prod;

        case (state_q)
            StIdle: begin
                if (start && is_muldiv(op)) begin
                    state_d = StRun;
                    cnt_d   = '0;
                    div_d   = op[1];
                    sgn_d   = sgn_in;
                    a_d     = a;
                    b_d     = b;
                    upper_d = '0;
                    lower_d = a_mag;
                    opnd_d  = b_mag;
                end else if (start && op == OpMthi) begin
                    hi_d    = a;
                    state_d = StDone;
                end else if (start && op == OpMtlo) begin
                    lo_d    = a;
                    state_d = StDone;
                end
            end
            StRun: begin
                upper_d = step_upper;
                lower_d = step_lower;
                cnt_d   = cnt_q + 7'd1;
                if (cnt_q == LastCnt) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                state_d = StDone;
                if (!div_q) begin
                    prod_fix = (sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -prod : prod;
                    hi_d     = prod_fix[2*WIDTH-1:WIDTH];
                    lo_d     = prod_fix[WIDTH-1:0];
                end else if (b_q == '0) begin
                    hi_d      = a_q;
                    lo_d      = '1;
                    divzero_d = 1'b1;
                end else begin
                    // Quotient negates on sign mismatch; remainder follows the dividend.
                    // Most-negative / -1 falls out naturally as quotient = a, rem = 0.
                    lo_d = (sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -lower_q : lower_q;
                    hi_d = (sgn_q && a_q[WIDTH-1]) ? -upper_q : upper_q;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and architectural registers; reset wipes everything immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            div_q     <= 1'b0;
            sgn_q     <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            upper_q   <= '0;
            lower_q   <= '0;
            opnd_q    <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            divzero_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            div_q     <= div_d;
            sgn_q     <= sgn_d;
            a_q       <= a_d;
            b_q       <= b_d;
            upper_q   <= upper_d;
            lower_q   <= lower_d;
            opnd_q    <= opnd_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            divzero_q <= divzero_d;
        end
    end

    // Status outputs decoded from the state register.
    always_comb begin
        busy    = (state_q == StRun) || (state_q == StFix);
        done    = (state_q == StDone);
        divzero = divzero_q;
        hi      = hi_q;
        lo      = lo_q;
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit (WIDTH = 32): directed corner cases,
// randomized ops against a plain-arithmetic reference model, reserved ops,
// start-while-busy and reset mid-operation.
module tb_muldiv_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [2:0]   op;
    logic [W-1:0] a, b;
    logic         busy, done, divzero;
    logic [W-1:0] hi, lo;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_hi, exp_lo;

`ifdef MULDIV_SIGNED_EN
    localparam bit SignedEn = 1'b1;
`else
    localparam bit SignedEn = 1'b0;
`endif

    muldiv_unit #(
        .WIDTH (W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .op      (op),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .divzero (divzero),
        .hi      (hi),
        .lo      (lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference: architectural result of one op from plain arithmetic.
    task automatic model(input logic [2:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                         inout logic [W-1:0] mh, inout logic [W-1:0] ml, output bit mdz);
        longint unsigned up;
        longint          sa, sb, sp, sq, sr;
        bit              sgn;
        mdz = 1'b0;
        sgn = SignedEn && o[0];
        sa  = $signed(va);
        sb  = $signed(vb);
        case (o)
            3'b000, 3'b001: begin
                if (sgn) begin
                    sp = sa * sb;
                    mh = sp[63:32];
                    ml = sp[31:0];
                end else begin
                    up = longint'(va) * longint'(vb);
                    mh = up[63:32];
                    ml = up[31:0];
                end
            end
            3'b010, 3'b011: begin
                if (vb == 0) begin
                    mh  = va;
                    ml  = '1;
                    mdz = 1'b1;
                end else if (sgn) begin
                    sq = sa / sb;
                    sr = sa % sb;
                    mh = sr[31:0];
                    ml = sq[31:0];
                end else begin
                    mh = va % vb;
                    ml = va / vb;
                end
            end
            3'b100: mh = va;
            3'b101: ml = va;
            default: ;
        endcase
    endtask

    // Issue one op and follow it to completion. With stress, start stays high
    // with fresh random operands throughout busy and done.
    task automatic do_op(input logic [2:0] o, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input bit stress, input string tag);
        logic [W-1:0] old_hi, old_lo;
        bit           edz, mt;
        int           busy_cnt, dz_cnt, done_k, hold_bad;
        logic         dz_at_done;
        mt     = o[2];
        old_hi = exp_hi;
        old_lo = exp_lo;
        model(o, va, vb, exp_hi, exp_lo, edz);
        @(posedge clk); #1;
        start = 1'b1; op = o; a = va; b = vb;
        busy_cnt = 0; dz_cnt = 0; done_k = 0; hold_bad = 0; dz_at_done = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            if (stress) begin
                a  = $urandom;
                b  = $urandom;
                op = 3'($urandom_range(0, 5));
            end else begin
                start = 1'b0;
            end
            if (busy) busy_cnt++;
            if (divzero) dz_cnt++;
            if (done) begin
                done_k     = k;
                dz_at_done = divzero;
                break;
            end
            if (hi !== old_hi || lo !== old_lo) hold_bad++;
        end
        check({tag, "_done_latency"}, done_k, mt ? 1 : 34);
        check({tag, "_busy_cycles"}, busy_cnt, mt ? 0 : 33);
        check({tag, "_hilo_hold"}, hold_bad, 0);
        check({tag, "_hi"}, hi, exp_hi);
        check({tag, "_lo"}, lo, exp_lo);
        check({tag, "_divzero"}, dz_at_done, edz);
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, "_done_pulse"}, {done, busy, divzero}, 3'b000);
        check({tag, "_dz_cycles"}, dz_cnt, edz ? 1 : 0);
        if (stress) begin
            check({tag, "_hi_after_ignored"}, hi, exp_hi);
            check({tag, "_lo_after_ignored"}, lo, exp_lo);
        end
    endtask

    initial begin
        int seen;
        logic [2:0]   ro;
        logic [W-1:0] ra, rb;

        reset = 1'b1; start = 1'b0; op = '0; a = '0; b = '0;
        exp_hi = '0; exp_lo = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_outputs", {busy, done, divzero, hi, lo}, '0);
        reset = 1'b0;

        do_op(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "multu_ff");
        check("multu_ff_hi_lit", hi, 32'hFFFF_FFFE);
        check("multu_ff_lo_lit", lo, 32'h0000_0001);

        do_op(3'b001, -32'sd3, 32'd5, 1'b0, "mult_m3_5");
        check("mult_m3_5_hi_lit", hi, SignedEn ? 32'hFFFF_FFFF : 32'h0000_0004);
        check("mult_m3_5_lo_lit", lo, 32'hFFFF_FFF1);

        do_op(3'b011, -32'sd7, 32'd2, 1'b1, "div_m7_2");
        check("div_m7_2_lo_lit", lo, SignedEn ? 32'hFFFF_FFFD : 32'h7FFF_FFFC);
        check("div_m7_2_hi_lit", hi, SignedEn ? 32'hFFFF_FFFF : 32'h0000_0001);

        do_op(3'b011, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, "div_ovf");
        check("div_ovf_lo_lit", lo, SignedEn ? 32'h8000_0000 : 32'h0000_0000);
        check("div_ovf_hi_lit", hi, SignedEn ? 32'h0000_0000 : 32'h8000_0000);

        do_op(3'b010, 32'd10, 32'd0, 1'b0, "divu_by0");
        check("divu_by0_lo_lit", lo, 32'hFFFF_FFFF);
        check("divu_by0_hi_lit", hi, 32'h0000_000A);

        do_op(3'b100, 32'h1234_5678, 32'h0, 1'b1, "mthi");
        check("mthi_hi_lit", hi, 32'h1234_5678);
        do_op(3'b101, 32'hCAFE_F00D, 32'h0, 1'b0, "mtlo");

        // Reserved ops must leave everything untouched.
        for (int r = 6; r <= 7; r++) begin
            @(posedge clk); #1;
            start = 1'b1; op = 3'(r); a = $urandom; b = $urandom;
            seen = 0;
            repeat (4) begin
                @(posedge clk); #1;
                start = 1'b0;
                if (busy || done) seen++;
            end
            check("reserved_no_activity", seen, 0);
            check("reserved_hi", hi, exp_hi);
            check("reserved_lo", lo, exp_lo);
        end

        // Random ops with occasional divide corner operands.
        for (int i = 0; i < 40; i++) begin
            ro = 3'($urandom_range(0, 5));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: rb = '0;
                1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
                2: rb = 32'($urandom_range(1, 15));
                default: ;
            endcase
            do_op(ro, ra, rb, i[2] & i[0], "rand");
        end

        // Make sure HI/LO are nonzero going into the abort.
        do_op(3'b000, 32'h0001_2345, 32'h0006_789A, 1'b0, "pre_abort");

        // Abort a MULTU in its tenth RUN cycle.
        @(posedge clk); #1;
        start = 1'b1; op = 3'b000; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("abort_outputs_zero", {busy, done, divzero, hi, lo}, '0);
        exp_hi = '0;
        exp_lo = '0;
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (busy || done) seen++;
        end
        check("abort_no_done", seen, 0);
        check("abort_hi", hi, 32'h0);
        check("abort_lo", lo, 32'h0);
        do_op(3'b000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "post_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
